// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module : rv32i_pkg
// Brief  : Opcodes, funct fields, ALU/writeback selects and helpers for the
//          RV32I single-cycle core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_t;

   typedef enum logic [1:0] {
      WB_ALU, WB_MEM, WB_PC4
   } wb_sel_t;

   // alt selects SUB/SRA; callers must only set it where bit 30 is meaningful
   function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      op = ALU_ADD;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         F3_AND:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_single_cycle_core_alu.sv
// ============================================================================
// Module : rv32i_alu
// Brief  : Combinational RV32I ALU with branch compare flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_alu
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_t         op,
   output logic [XLEN-1:0] result,
   output logic            eq,
   output logic            lt,
   output logic            ltu
);

   logic [4:0] shamt;

   assign shamt = b[4:0];
   assign eq    = (a == b);
   assign lt    = ($signed(a) < $signed(b));
   assign ltu   = (a < b);

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_SLL:    result = a << shamt;
         ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt};
         ALU_SLTU:   result = {{(XLEN-1){1'b0}}, ltu};
         ALU_XOR:    result = a ^ b;
         ALU_SRL:    result = a >> shamt;
         ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
         ALU_OR:     result = a | b;
         ALU_AND:    result = a & b;
         ALU_PASS_B: result = b;
         default:    result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rv32i_single_cycle_core.sv
// ============================================================================
// Module : rv32i_single_cycle_core
// Brief  : Single-cycle RV32I core with private instruction and data memories.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_single_cycle_core
   import rv32i_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              MEM_WORDS = 1024,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic clk,
   input  logic reset
);

   localparam int              AW   = $clog2(MEM_WORDS);
   localparam logic [XLEN-1:0] FOUR = 4;

   logic [XLEN-1:0] pc, pc_in, pc_plus4;
   logic [31:0]     instruction_mux_out;
   logic [XLEN-1:0] mux_a_out, mux_b_out, alu_out;
   logic [XLEN-1:0] rs1_data, rs2_data, wb_data, load_data;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [4:0]      rs1, rs2, rd;
   logic            eq, lt, ltu;
   logic            a_sel_pc, b_sel_imm, reg_we, mem_we;
   logic            is_branch, is_jal, is_jalr, branch_taken;
   alu_op_t         alu_op;
   wb_sel_t         wb_sel;

   // Storage lives in named scopes so state can be probed and preloaded by name
   if (1) begin : insn_memory
      logic [31:0] mem [0:MEM_WORDS-1];
   end

   if (1) begin : data_memory
      logic [31:0] mem [0:MEM_WORDS-1];
      always_ff @(posedge clk) begin
         if (mem_we) mem[alu_out[AW+1:2]] <= rs2_data;
      end
   end

   if (1) begin : register_file
      logic [XLEN-1:0] regFile [0:31];
      always_ff @(posedge clk) begin
         if (reg_we && (rd != 5'd0)) regFile[rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc <= RESET_PC;
      else       pc <= pc_in;
   end

   assign instruction_mux_out = reset ? NOP : insn_memory.mem[pc[AW+1:2]];

   assign opcode = instruction_mux_out[6:0];
   assign rd     = instruction_mux_out[11:7];
   assign funct3 = instruction_mux_out[14:12];
   assign rs1    = instruction_mux_out[19:15];
   assign rs2    = instruction_mux_out[24:20];
   assign funct7 = instruction_mux_out[31:25];

   assign imm_i = {{(XLEN-12){instruction_mux_out[31]}}, instruction_mux_out[31:20]};
   assign imm_s = {{(XLEN-12){instruction_mux_out[31]}}, instruction_mux_out[31:25],
                   instruction_mux_out[11:7]};
   assign imm_b = {{(XLEN-13){instruction_mux_out[31]}}, instruction_mux_out[31],
                   instruction_mux_out[7], instruction_mux_out[30:25],
                   instruction_mux_out[11:8], 1'b0};
   assign imm_u = {{(XLEN-32){instruction_mux_out[31]}}, instruction_mux_out[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){instruction_mux_out[31]}}, instruction_mux_out[31],
                   instruction_mux_out[19:12], instruction_mux_out[20],
                   instruction_mux_out[30:21], 1'b0};

   // Every write enable defaults low so unknown encodings retire as pc+4 no-ops
   always_comb begin
      alu_op    = ALU_ADD;
      wb_sel    = WB_ALU;
      imm       = imm_i;
      a_sel_pc  = 1'b0;
      b_sel_imm = 1'b1;
      reg_we    = 1'b0;
      mem_we    = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      case (opcode)
         OPC_OP: begin
            b_sel_imm = 1'b0;
            alu_op    = alu_decode(funct3, funct7[5]);
            reg_we    = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
         end
         OPC_OP_IMM: begin
            alu_op = alu_decode(funct3, (funct3 == F3_SR) && funct7[5]);
            if (funct3 == F3_SLL)     reg_we = (funct7 == F7_BASE);
            else if (funct3 == F3_SR) reg_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            else                      reg_we = 1'b1;
         end
         OPC_LOAD: begin
            wb_sel = WB_MEM;
            reg_we = (funct3 == F3_WORD);
         end
         OPC_STORE: begin
            imm    = imm_s;
            mem_we = (funct3 == F3_WORD);
         end
         OPC_BRANCH: begin
            b_sel_imm = 1'b0;
            imm       = imm_b;
            is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
         end
         OPC_JAL: begin
            a_sel_pc = 1'b1;
            imm      = imm_j;
            wb_sel   = WB_PC4;
            reg_we   = 1'b1;
            is_jal   = 1'b1;
         end
         OPC_JALR: begin
            wb_sel  = WB_PC4;
            reg_we  = (funct3 == 3'b000);
            is_jalr = (funct3 == 3'b000);
         end
         OPC_LUI: begin
            imm    = imm_u;
            alu_op = ALU_PASS_B;
            reg_we = 1'b1;
         end
         OPC_AUIPC: begin
            a_sel_pc = 1'b1;
            imm      = imm_u;
            reg_we   = 1'b1;
         end
         default: ;
      endcase
   end

   assign rs1_data  = (rs1 == 5'd0) ? '0 : register_file.regFile[rs1];
   assign rs2_data  = (rs2 == 5'd0) ? '0 : register_file.regFile[rs2];
   assign mux_a_out = a_sel_pc ? pc : rs1_data;
   assign mux_b_out = b_sel_imm ? imm : rs2_data;

   rv32i_alu #(.XLEN(XLEN)) u_alu (
      .a      (mux_a_out),
      .b      (mux_b_out),
      .op     (alu_op),
      .result (alu_out),
      .eq     (eq),
      .lt     (lt),
      .ltu    (ltu)
   );

   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         F3_BEQ:  branch_taken = eq;
         F3_BNE:  branch_taken = !eq;
         F3_BLT:  branch_taken = lt;
         F3_BGE:  branch_taken = !lt;
         F3_BLTU: branch_taken = ltu;
         F3_BGEU: branch_taken = !ltu;
         default: branch_taken = 1'b0;
      endcase
   end

   assign load_data = data_memory.mem[alu_out[AW+1:2]];
   assign pc_plus4  = pc + FOUR;

   always_comb begin
      wb_data = alu_out;
      case (wb_sel)
         WB_MEM:  wb_data = load_data;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_out;
      endcase
   end

   // JAL target comes out of the ALU (pc + imm_j); branches use a dedicated adder
   always_comb begin
      if (is_jal)                          pc_in = alu_out;
      else if (is_jalr)                    pc_in = {alu_out[XLEN-1:1], 1'b0};
      else if (is_branch && branch_taken)  pc_in = pc + imm;
      else                                 pc_in = pc_plus4;
   end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_single_cycle_core.sv
// ============================================================================
// Module : tb_rv32i_single_cycle_core
// Brief  : Directed self-checking bench for rv32i_single_cycle_core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_single_cycle_core;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JALR   = 7'b1100111;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [31:0] marker;

   rv32i_single_cycle_core dut (
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         dut.insn_memory.mem[i] = 32'h0;
         dut.data_memory.mem[i] = 32'h0;
      end
      for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = k;
      dut.register_file.regFile[5] = 32'hFFFF_FFF8;
      dut.register_file.regFile[6] = 32'h0000_0002;

      dut.insn_memory.mem[0]  = enc_i(12'd20, 5'd1, 3'b000, 5'd1, OP_IMM);
      dut.insn_memory.mem[1]  = enc_i(12'd20, 5'd2, 3'b000, 5'd2, OP_IMM);
      dut.insn_memory.mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3, OP);
      dut.insn_memory.mem[3]  = enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd7, OP);
      dut.insn_memory.mem[4]  = enc_r(7'h20, 5'd6, 5'd5, 3'b101, 5'd8, OP);
      dut.insn_memory.mem[5]  = enc_r(7'h00, 5'd6, 5'd5, 3'b101, 5'd9, OP);
      dut.insn_memory.mem[6]  = enc_s(12'd8, 5'd6, 5'd0, 3'b010);
      dut.insn_memory.mem[7]  = enc_i(12'd8, 5'd0, 3'b010, 5'd10, LOAD);
      dut.insn_memory.mem[8]  = enc_i(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM);
      dut.insn_memory.mem[9]  = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
      dut.insn_memory.mem[10] = enc_i(12'd99, 5'd0, 3'b000, 5'd11, OP_IMM);
      dut.insn_memory.mem[11] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
      dut.insn_memory.mem[12] = enc_j(21'd16, 5'd12);
      dut.insn_memory.mem[16] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd13, OP_IMM);
      dut.insn_memory.mem[17] = enc_r(7'h00, 5'd13, 5'd0, 3'b011, 5'd14, OP);
      dut.insn_memory.mem[18] = enc_r(7'h00, 5'd0, 5'd13, 3'b010, 5'd15, OP);
      dut.insn_memory.mem[19] = {20'h12345, 5'd16, LUI};
      dut.insn_memory.mem[20] = {20'h00001, 5'd17, AUIPC};
      dut.insn_memory.mem[21] = enc_i(12'd129, 5'd0, 3'b000, 5'd18, JALR);
      dut.insn_memory.mem[22] = enc_i(12'd1, 5'd0, 3'b000, 5'd19, OP_IMM);

      @(negedge clk);
      @(negedge clk);
      check("reset_pc", dut.pc, 32'h0);
      check("reset_nop", dut.instruction_mux_out, 32'h0000_0013);
      reset = 1'b0;
      #1;
      check("fetch0", dut.instruction_mux_out, enc_i(12'd20, 5'd1, 3'b000, 5'd1, OP_IMM));

      step();
      check("addi_x1", dut.register_file.regFile[1], 32'd21);
      check("pc_4", dut.pc, 32'd4);
      step();
      check("addi_x2", dut.register_file.regFile[2], 32'd22);
      check("sll_a", dut.mux_a_out, 32'd21);
      check("sll_b", dut.mux_b_out, 32'd22);
      check("sll_alu", dut.alu_out, 32'h0540_0000);
      step();
      check("sll_x3", dut.register_file.regFile[3], 32'h0540_0000);
      check("pc_12", dut.pc, 32'd12);
      step();
      check("sub_x7", dut.register_file.regFile[7], 32'hFFFF_FFF6);
      step();
      check("sra_x8", dut.register_file.regFile[8], 32'hFFFF_FFFE);
      step();
      check("srl_x9", dut.register_file.regFile[9], 32'h3FFF_FFFE);
      step();
      check("sw_mem2", dut.data_memory.mem[2], 32'd2);
      step();
      check("lw_x10", dut.register_file.regFile[10], 32'd2);
      step();
      check("x0_stays_0", dut.register_file.regFile[0], 32'd0);
      check("pc_36", dut.pc, 32'd36);
      step();
      check("beq_taken_pc", dut.pc, 32'd44);
      step();
      check("bne_fall_pc", dut.pc, 32'd48);
      step();
      check("jal_pc", dut.pc, 32'd64);
      check("jal_link", dut.register_file.regFile[12], 32'd52);
      check("skipped_x11", dut.register_file.regFile[11], 32'd11);
      step();
      check("addi_neg_x13", dut.register_file.regFile[13], 32'hFFFF_FFFF);
      step();
      check("sltu_x14", dut.register_file.regFile[14], 32'd1);
      step();
      check("slt_x15", dut.register_file.regFile[15], 32'd1);
      step();
      check("lui_x16", dut.register_file.regFile[16], 32'h1234_5000);
      step();
      check("auipc_x17", dut.register_file.regFile[17], 32'h0000_1050);
      step();
      check("jalr_pc", dut.pc, 32'd128);
      check("jalr_link", dut.register_file.regFile[18], 32'd88);
      check("skipped_x19", dut.register_file.regFile[19], 32'd19);

      #2 reset = 1'b1;
      #1;
      check("async_reset_pc", dut.pc, 32'h0);
      check("async_reset_nop", dut.instruction_mux_out, 32'h0000_0013);
      check("reset_keeps_x1", dut.register_file.regFile[1], 32'd21);
      @(negedge clk);
      check("reset_keeps_x12", dut.register_file.regFile[12], 32'd52);
      reset = 1'b0;
      step();
      check("restart_x1", dut.register_file.regFile[1], 32'd41);
      check("restart_pc", dut.pc, 32'd4);

      reset = 1'b1;
      for (int i = 0; i < 1024; i++) dut.insn_memory.mem[i] = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      step();
      check("zero_pc_4", dut.pc, 32'd4);
      marker = enc_i(12'd7, 5'd0, 3'b000, 5'd20, OP_IMM);
      dut.insn_memory.mem[0] = marker;
      for (int n = 0; n < 1023; n++) step();
      check("zero_pc_4096", dut.pc, 32'd4096);
      check("wrap_fetch", dut.instruction_mux_out, marker);
      check("zero_keeps_x1", dut.register_file.regFile[1], 32'd41);
      check("zero_keeps_x20", dut.register_file.regFile[20], 32'd20);
      step();
      check("wrap_exec_x20", dut.register_file.regFile[20], 32'd7);
      check("wrap_pc_4100", dut.pc, 32'd4100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
